// File: rtl/lc3_pkg.sv
// lc3_pkg
//   Shared constants for the LC-3 memory responder: memory-mapped I/O
//   register addresses and the upper-address tag that selects the
//   MMIO page (xFE00-xFFFF).
package lc3_pkg;

  localparam logic [15:0] ADDR_KBSR    = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR    = 16'hFE02;
  localparam logic [15:0] ADDR_DSR     = 16'hFE04;
  localparam logic [15:0] ADDR_DDR     = 16'hFE06;
  localparam logic [6:0]  MMIO_BASE_HI = 7'h7F;

  // True when the address falls inside the MMIO page.
  function automatic logic is_mmio(input logic [15:0] addr);
    return addr[15:9] == MMIO_BASE_HI;
  endfunction

endpackage

// File: rtl/lc3_kb_fifo.sv
// lc3_kb_fifo
//   Keyboard character FIFO, DEPTH entries of 8 bits (DEPTH a power of two).
//   Ports:
//     clk, reset  clock and asynchronous active-high reset
//     push, din   enqueue din (caller guarantees !full)
//     pop         drop the head entry (caller guarantees !empty)
//     dout        current head entry (combinational)
//     empty, full occupancy flags
module lc3_kb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    storage [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = storage[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

endmodule

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder
//   LC-3 memory system: 2**RAM_AW words of RAM (aliased across the
//   non-MMIO address space) plus keyboard and display MMIO registers.
//   Ports:
//     clk, reset          clock, asynchronous active-high reset
//     mar, mdr, memwe     CPU address, write data, write strobe
//     memOut              read data, combinational from mar
//     kb_valid/kb_data    keyboard source offering a character
//     kb_ready            keyboard FIFO can accept a character
//     dsp_valid/dsp_data  pending display character
//     dsp_ready           display consumes the character
module lc3_mem_responder
  import lc3_pkg::*;
#(
  parameter int RAM_AW   = 10,
  parameter int KB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mar,
  input  logic [15:0] mdr,
  input  logic        memwe,
  output logic [15:0] memOut,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  output logic        dsp_valid,
  output logic [7:0]  dsp_data,
  input  logic        dsp_ready
);

  logic [15:0] ram [1 << RAM_AW];

  logic [15:0] mar_q;
  logic        mmio;
  logic        acc_evt;
  logic        kb_push;
  logic        kb_pop;
  logic [7:0]  kb_head;
  logic        kb_empty;
  logic        kb_full;
  logic        ddr_wr;
  logic        dsp_hs;

  assign mmio    = is_mmio(mar);
  // The CPU holds mar for several cycles per access; only a change of
  // address counts as a new access, so a held KBDR read pops once.
  assign acc_evt = (mar != mar_q);
  assign kb_pop  = acc_evt && (mar == ADDR_KBDR) && !kb_empty;
  assign kb_push = kb_valid && kb_ready;
  assign kb_ready = !kb_full;

  assign ddr_wr = memwe && (mar == ADDR_DDR);
  assign dsp_hs = dsp_valid && dsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mar_q <= 16'hFFFF;
    else       mar_q <= mar;
  end

  // RAM: synchronous write, asynchronous read, never reset.
  always_ff @(posedge clk) begin
    if (memwe && !mmio) ram[mar[RAM_AW-1:0]] <= mdr;
  end

  lc3_kb_fifo #(.DEPTH(KB_DEPTH)) u_kb_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (kb_push),
    .pop   (kb_pop),
    .din   (kb_data),
    .dout  (kb_head),
    .empty (kb_empty),
    .full  (kb_full)
  );

  // A completing handshake takes priority; a DDR write that coincides
  // with it, or lands while a character is still pending, is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dsp_valid <= 1'b0;
      dsp_data  <= 8'h00;
    end else if (dsp_hs) begin
      dsp_valid <= 1'b0;
    end else if (ddr_wr && !dsp_valid) begin
      dsp_valid <= 1'b1;
      dsp_data  <= mdr[7:0];
    end
  end

  always_comb begin
    memOut = 16'h0000;
    if (!mmio) begin
      memOut = ram[mar[RAM_AW-1:0]];
    end else begin
      case (mar)
        ADDR_KBSR: memOut = {!kb_empty, 15'b0};
        ADDR_KBDR: memOut = kb_empty ? 16'h0000 : {8'h00, kb_head};
        ADDR_DSR:  memOut = {!dsp_valid, 15'b0};
        ADDR_DDR:  memOut = {8'h00, dsp_data};
        default:   memOut = 16'h0000;
      endcase
    end
  end

endmodule
